// File: rtl/cw_restore.sv
// Codeword restore: scatters a hard-decision codeword from the reordered (lambda2) domain
// back to original order, one position per cycle, flagging any index that breaks the permutation.
module cw_restore #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       c_flat,
  input  logic [N*IDX_W-1:0] lambda2_flat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       x_flat,
  output logic               perm_err
);

  typedef enum logic [1:0] {IDLE, SCATTER, DONE} state_t;

  localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(N);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

  state_t             state_q, state_d;
  logic [N-1:0]       c_q, c_d;
  logic [N*IDX_W-1:0] lam_q, lam_d;
  logic [N-1:0]       x_q, x_d;
  logic [N-1:0]       seen_q, seen_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx;
  logic               in_range;

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    lam_d    = lam_q;
    x_d      = x_q;
    seen_d   = seen_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    idx      = lam_q[int'(cnt_q)*IDX_W +: IDX_W];
    in_range = ({1'b0, idx} < N_EXT);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          c_d     = c_flat;
          lam_d   = lambda2_flat;
          x_d     = '0;
          seen_d  = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = SCATTER;
        end
      end
      SCATTER: begin
        // Out-of-range or repeated targets only raise the error; the first write to a slot wins.
        if (in_range && !seen_q[idx]) begin
          x_d[idx]    = c_q[cnt_q];
          seen_d[idx] = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      lam_q   <= '0;
      x_q     <= '0;
      seen_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      lam_q   <= lam_d;
      x_q     <= x_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign x_flat    = x_q;
  assign perm_err  = err_q;

endmodule

// File: tb/tb_cw_restore.sv
// Directed and table-driven bench for cw_restore (N=8): permutation vectors, round trip,
// backpressure and asynchronous reset during a codeword.
module tb_cw_restore;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       c_flat;
  logic [N*IDX_W-1:0] lambda2_flat;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       x_flat;
  logic               perm_err;

  int n_chk  = 0;
  int n_fail = 0;

  cw_restore #(.N(N), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .c_flat       (c_flat),
    .lambda2_flat (lambda2_flat),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .x_flat       (x_flat),
    .perm_err     (perm_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic [N-1:0]       c;
    logic [N*IDX_W-1:0] lam;
    logic [N-1:0]       exp_x;
    logic               exp_err;
  } vec_t;

  function automatic logic [N*IDX_W-1:0] pk(input int l0, l1, l2, l3, l4, l5, l6, l7);
    logic [N*IDX_W-1:0] r;
    r[0*IDX_W +: IDX_W] = IDX_W'(l0);
    r[1*IDX_W +: IDX_W] = IDX_W'(l1);
    r[2*IDX_W +: IDX_W] = IDX_W'(l2);
    r[3*IDX_W +: IDX_W] = IDX_W'(l3);
    r[4*IDX_W +: IDX_W] = IDX_W'(l4);
    r[5*IDX_W +: IDX_W] = IDX_W'(l5);
    r[6*IDX_W +: IDX_W] = IDX_W'(l6);
    r[7*IDX_W +: IDX_W] = IDX_W'(l7);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits up to a bounded number of edges for out_valid; returns edge count or -1.
  task automatic wait_valid(output int edges);
    edges = -1;
    for (int k = 1; k <= 4*N; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        edges = k;
        break;
      end
    end
  endtask

  // Full transaction with out_ready held high; checks latency, result and return to IDLE.
  task automatic run_vec(input string name, input logic [N-1:0] c, input logic [N*IDX_W-1:0] lam,
                         input logic [N-1:0] exp_x, input logic exp_err, input bit full);
    int edges;
    out_ready    = 1'b1;
    c_flat       = c;
    lambda2_flat = lam;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (full) check({name, " in_ready_busy"}, 32'(in_ready), 32'd0);
    wait_valid(edges);
    if (full) check({name, " latency"}, edges, N);
    else if (edges < 0) check({name, " timeout"}, edges, N);
    check({name, " x_flat"}, 32'(x_flat), 32'(exp_x));
    check({name, " perm_err"}, 32'(perm_err), 32'(exp_err));
    @(posedge clk); #1;
    if (full) begin
      check({name, " back_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
      check({name, " x_keep"}, 32'(x_flat), 32'(exp_x));
    end
  endtask

  vec_t vecs[6];

  initial begin
    int edges;
    int lam_a[N];
    logic [5:0] z[N];
    logic [N*IDX_W-1:0] lam_r;
    logic [N-1:0] c_r, x_r;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; c_flat = '0; lambda2_flat = '0;

    vecs[0] = '{"identity", 8'hA5, pk(0,1,2,3,4,5,6,7), 8'hA5, 1'b0};
    vecs[1] = '{"reversal", 8'b0000_0011, pk(7,6,5,4,3,2,1,0), 8'b1100_0000, 1'b0};
    vecs[2] = '{"duplicate", 8'b0000_0010, pk(3,3,0,1,2,4,5,6), 8'h00, 1'b1};
    vecs[3] = '{"rotate", 8'b1000_0001, pk(1,2,3,4,5,6,7,0), 8'b0000_0011, 1'b0};
    vecs[4] = '{"all_zero_idx", 8'hFF, pk(0,0,0,0,0,0,0,0), 8'h01, 1'b1};
    vecs[5] = '{"pair_swap", 8'h55, pk(1,0,3,2,5,4,7,6), 8'hAA, 1'b0};

    #3;
    check("reset_state", {28'd0, in_ready, out_valid, perm_err, 1'b0} | 32'(x_flat) << 8, 32'd8);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i].name, vecs[i].c, vecs[i].lam, vecs[i].exp_x, vecs[i].exp_err, 1'b1);

    // Round trip through the forward reorder V[j] = Z[lambda2[j]] using sign bits.
    for (int t = 0; t < 1000; t++) begin
      for (int i = 0; i < N; i++) begin
        lam_a[i] = i;
        z[i] = 6'($urandom_range(0, 63));
      end
      for (int i = N-1; i > 0; i--) begin
        int r, tmp;
        r = int'($urandom_range(0, i));
        tmp = lam_a[i]; lam_a[i] = lam_a[r]; lam_a[r] = tmp;
      end
      for (int j = 0; j < N; j++) begin
        lam_r[j*IDX_W +: IDX_W] = IDX_W'(lam_a[j]);
        c_r[j] = z[lam_a[j]][5];
      end
      for (int i = 0; i < N; i++) x_r[i] = z[i][5];
      run_vec("round_trip", c_r, lam_r, x_r, 1'b0, 1'b0);
    end

    // Backpressure, with inputs changing during SCATTER and DONE.
    out_ready = 1'b0;
    c_flat = 8'hA5; lambda2_flat = pk(0,1,2,3,4,5,6,7); in_valid = 1'b1;
    @(posedge clk); #1;
    c_flat = 8'hFF; lambda2_flat = pk(7,6,5,4,3,2,1,0);
    wait_valid(edges);
    check("bp latency", edges, N);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      c_flat = 8'(k * 37);
      check("bp hold", {22'd0, out_valid, in_ready, x_flat}, {22'd0, 2'b10, 8'hA5});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release", {22'd0, out_valid, in_ready, x_flat}, {22'd0, 2'b01, 8'hA5});
    check("bp perm_err", 32'(perm_err), 32'd0);

    // Reset three edges into SCATTER.
    c_flat = 8'hFF; lambda2_flat = pk(0,1,2,3,4,5,6,7); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset x", 32'(x_flat), 32'h07);
    rst_n = 1'b0;
    #1;
    check("reset_abort", {21'd0, out_valid, in_ready, perm_err, x_flat}, {21'd0, 3'b010, 8'h00});
    @(posedge clk); #1;
    rst_n = 1'b1;
    edges = 0;
    for (int k = 0; k < 2*N; k++) begin
      @(posedge clk); #1;
      if (out_valid) edges++;
    end
    check("no_valid_after_reset", edges, 0);
    run_vec("identity_after_reset", 8'hA5, pk(0,1,2,3,4,5,6,7), 8'hA5, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
